// File: rtl/decoder_scan_driver.sv
// Sequences select/enable for a 3-to-8 decoder; every select value gets a PRESCALE-cycle slot of blank then active.
// Latency: all outputs registered, one cycle after run/step is sampled in IDLE.
// Backpressure: none; step is dropped while busy, run is sampled at each slot end.
module decoder_scan_driver #(
    parameter int PRESCALE = 8,
    parameter int BLANK    = 2,
    parameter int PW       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [2:0] last_sel,
    output logic       e,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       wrap,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [PW-1:0] SLOT_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_LAST = (BLANK > 0) ? PW'(BLANK - 1) : '0;
    // With no blanking a slot opens directly in ACTIVE and the counter covers the whole slot.
    localparam state_t SLOT_START = (BLANK > 0) ? S_BLANK : S_ACTIVE;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          single_q, single_d;
    logic          e_q, e_d;
    logic          wrap_q, wrap_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        single_d = single_q;
        wrap_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d  = SLOT_START;
                    cnt_d    = '0;
                    single_d = 1'b0;
                end else if (step) begin
                    state_d  = SLOT_START;
                    cnt_d    = '0;
                    single_d = 1'b1;
                end
            end

            S_BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    // Select moves on the same edge that drops e, so no output ghosts.
                    if (sel_q >= last_sel) begin
                        sel_d  = 3'd0;
                        wrap_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                    cnt_d = '0;
                    if (run && !single_q) begin
                        state_d = SLOT_START;
                    end else begin
                        state_d  = S_IDLE;
                        single_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                single_d = 1'b0;
            end
        endcase

        e_d    = (state_d == S_ACTIVE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= 3'd0;
            single_q <= 1'b0;
            e_q      <= 1'b0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            single_q <= single_d;
            e_q      <= e_d;
            wrap_q   <= wrap_d;
            busy_q   <= busy_d;
        end
    end

    assign e    = e_q;
    assign a    = sel_q[2];
    assign b    = sel_q[1];
    assign c    = sel_q[0];
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Randomised and directed bench for decoder_scan_driver with a slot-position reference model and queue scoreboard.
module tb_decoder_scan_driver;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic       clk;
    logic       rst;
    logic       run;
    logic       step;
    logic [2:0] last_sel;
    logic       e, a, b, c, wrap, busy;

    decoder_scan_driver #(.PRESCALE(PRESCALE), .BLANK(BLANK), .PW(17)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .last_sel (last_sel),
        .e        (e),
        .a        (a),
        .b        (b),
        .c        (c),
        .wrap     (wrap),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: the scan is a position within a PRESCALE-long slot (-1 when idle);
    // e is simply "position past the blanking part", busy is "inside a slot".
    logic [5:0] exp_q[$];
    int  m_pos    = -1;
    int  m_sel    = 0;
    bit  m_single = 0;

    always @(posedge clk) begin
        bit m_wrap;
        logic [5:0] v;
        cyc++;
        m_wrap = 0;
        if (rst) begin
            m_pos = -1; m_sel = 0; m_single = 0;
        end else if (m_pos < 0) begin
            if (run)       begin m_pos = 0; m_single = 0; end
            else if (step) begin m_pos = 0; m_single = 1; end
        end else if (m_pos == PRESCALE - 1) begin
            if (m_sel >= int'(last_sel)) begin m_sel = 0; m_wrap = 1; end
            else m_sel = m_sel + 1;
            if (run && !m_single) m_pos = 0;
            else begin m_pos = -1; m_single = 0; end
        end else begin
            m_pos = m_pos + 1;
        end
        v = {(m_pos >= BLANK), m_sel[2:0], m_wrap, (m_pos >= 0)};
        exp_q.push_back(v);
    end

    // Monitor: the DUT presents a new output vector every cycle.
    logic [2:0] prev_sel = 3'd0;
    always @(negedge clk) begin
        logic [5:0] want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("outputs{e,sel,wrap,busy}", int'({e, a, b, c, wrap, busy}), int'(want));
        end
        if (e) check("no_ghost_sel_change", int'({a, b, c}), int'(prev_sel));
        prev_sel = {a, b, c};
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_wrap(output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wrap) begin t = cyc; return; end
        end
        check("wrap_timeout", 0, 1);
    endtask

    task automatic wait_sel_active(input logic [2:0] s);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (e && {a, b, c} == s) return;
        end
        check("wait_sel_active_timeout", int'({a, b, c}), int'(s));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    initial begin
        int t0, t1, bcnt;
        rst = 1'b1; run = 1'b0; step = 1'b0; last_sel = 3'd7;

        // Reset, then stays idle with run low
        tick(2);
        check("reset_state", int'({e, a, b, c, wrap, busy}), 0);
        rst = 1'b0;
        tick(5);
        check("idle_hold", int'({e, a, b, c, wrap, busy}), 0);

        // Full scan 0..7: wrap period 8 slots
        run = 1'b1; last_sel = 3'd7;
        wait_wrap(t0);
        wait_wrap(t1);
        check("wrap_period_last7", t1 - t0, 8 * PRESCALE);

        // Scan 0..2: wrap period 3 slots, then lower limit while sel=2
        last_sel = 3'd2;
        wait_wrap(t0);
        wait_wrap(t1);
        check("wrap_period_last2", t1 - t0, 3 * PRESCALE);
        wait_sel_active(3'd1);
        wait_sel_active(3'd2);
        last_sel = 3'd1;
        wait_wrap(t0);
        check("sel_after_lowered_limit", int'({a, b, c}), 0);

        // Drop run mid-ACTIVE at sel=3
        last_sel = 3'd7;
        wait_sel_active(3'd3);
        run = 1'b0;
        wait_idle();
        check("stop_sel", int'({a, b, c}), 4);
        check("stop_e", int'(e), 0);

        // Reset mid-ACTIVE at sel=5
        run = 1'b1;
        wait_sel_active(3'd5);
        rst = 1'b1;
        tick();
        check("midslot_reset", int'({e, a, b, c, wrap, busy}), 0);
        rst = 1'b0; run = 1'b0;
        tick(3);

        // Single step from sel=0
        step = 1'b1;
        tick();
        step = 1'b0;
        bcnt = 1;
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
            if (busy) bcnt++;
        end
        check("step_busy_cycles", bcnt, PRESCALE);
        check("step_sel", int'({a, b, c}), 1);

        // Step pulses while running are ignored
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step = ($urandom_range(0, 3) == 0);
            tick();
        end
        step = 1'b0;

        // Randomised phase
        for (int i = 0; i < 2500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) run = ~run;
            step = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) last_sel = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0; run = 1'b0; step = 1'b0;
        tick(2 * PRESCALE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
